// File: rtl/data_sram_resp.sv
// Data-side SRAM responder for the EX-stage request interface.
// Provides a single-port RAM with a registered (1-cycle) read and a small
// MMIO window (LED, NUM, TIMER) decoded ahead of the RAM. Reads are
// read-first: a store cycle returns the word held before the store.
module data_sram_resp #(
  parameter int          RAM_AW  = 16,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        mmio_err
);

  localparam logic [15:0] OFF_LED   = 16'h0000;
  localparam logic [15:0] OFF_NUM   = 16'h0004;
  localparam logic [15:0] OFF_TIMER = 16'h0008;

  logic [31:0]       ram [2**RAM_AW];
  logic [31:0]       num;
  logic [31:0]       timer;
  logic [31:0]       timer_inc;
  logic [31:0]       timer_next;
  logic [31:0]       mmio_rdata;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       mmio_off;
  logic              mmio_sel;
  logic              sel_led;
  logic              sel_num;
  logic              sel_timer;
  logic              sel_unmapped;
  logic              unused_addr_bits;

  // Byte offset bits are dropped: the requester only issues word addresses.
  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign mmio_sel     = (data_sram_addr[31:16] == MMIO_HI);
  assign mmio_off     = data_sram_addr[15:0];
  assign ram_idx      = data_sram_addr[RAM_AW+1:2];
  assign sel_led      = mmio_sel && (mmio_off == OFF_LED);
  assign sel_num      = mmio_sel && (mmio_off == OFF_NUM);
  assign sel_timer    = mmio_sel && (mmio_off == OFF_TIMER);
  assign sel_unmapped = mmio_sel && !(sel_led || sel_num || sel_timer);
  assign timer_inc    = timer + 32'd1;

  // MMIO read mux; unmapped offsets read back as zero.
  always_comb begin
    mmio_rdata = '0;
    if (sel_led)   mmio_rdata = {16'h0000, led};
    if (sel_num)   mmio_rdata = num;
    if (sel_timer) mmio_rdata = timer;
  end

  // Timer free-runs; written lanes override the incremented value.
  always_comb begin
    timer_next = timer_inc;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_en && sel_timer && data_sram_we[i]) begin
        timer_next[8*i +: 8] = data_sram_wdata[8*i +: 8];
      end
    end
  end

  // RAM array with per-byte write enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (resetn && data_sram_en && !mmio_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port: captures the pre-edge word, holds when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_sram_rdata <= '0;
    end else if (data_sram_en) begin
      data_sram_rdata <= mmio_sel ? mmio_rdata : ram[ram_idx];
    end
  end

  // LED register only has lanes 0 and 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= '0;
    end else if (data_sram_en && sel_led) begin
      if (data_sram_we[0]) led[7:0]  <= data_sram_wdata[7:0];
      if (data_sram_we[1]) led[15:8] <= data_sram_wdata[15:8];
    end
  end

  // NUM register, full 32-bit byte-writable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      num <= '0;
    end else if (data_sram_en && sel_num) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) num[8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // TIMER register update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= '0;
    end else begin
      timer <= timer_next;
    end
  end

  // Sticky error flag for any access to an unmapped MMIO offset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mmio_err <= 1'b0;
    end else if (data_sram_en && sel_unmapped) begin
      mmio_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic        mmio_err;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_LED   = 32'hBFAF_0000;
  localparam logic [31:0] A_NUM   = 32'hBFAF_0004;
  localparam logic [31:0] A_TIMER = 32'hBFAF_0008;
  localparam logic [31:0] A_BAD   = 32'hBFAF_0040;

  data_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .mmio_err        (mmio_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drive one request and advance past the next rising edge.
  task automatic applyStimulus(input logic en, input logic [3:0] we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
      end
  endtask

  // Linear directed sequence.
  initial begin
    clk             = 1'b0;
    resetn          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdata", data_sram_rdata, 32'h0);
    checkOutput("reset_led", {16'h0, led}, 32'h0);
    checkOutput("reset_err", {31'h0, mmio_err}, 32'h0);

    // Timer counts from 0 on the first edge out of reset.
    resetn = 1'b1;
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("timer_t0", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("timer_t1", data_sram_rdata, 32'h1);
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("timer_t2", data_sram_rdata, 32'h2);

    // Full-word RAM write then read.
    applyStimulus(1'b1, 4'b1111, 32'h0000_0010, 32'h1122_3344);
    applyStimulus(1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    checkOutput("ram_word", data_sram_rdata, 32'h1122_3344);

    // rdata holds while en is low.
    applyStimulus(1'b0, 4'b0000, 32'h0000_0020, 32'h0);
    checkOutput("rdata_hold", data_sram_rdata, 32'h1122_3344);

    // Upper address bits alias onto the same RAM word.
    applyStimulus(1'b1, 4'b0000, 32'h0004_0010, 32'h0);
    checkOutput("ram_alias", data_sram_rdata, 32'h1122_3344);

    // Byte-lane stores.
    applyStimulus(1'b1, 4'b1111, 32'h0000_0020, 32'hAABB_CCDD);
    applyStimulus(1'b1, 4'b0010, 32'h0000_0020, 32'h5A5A_5A5A);
    applyStimulus(1'b1, 4'b1100, 32'h0000_0020, 32'h1234_1234);
    applyStimulus(1'b1, 4'b0000, 32'h0000_0020, 32'h0);
    checkOutput("ram_bytes", data_sram_rdata, 32'h1234_5ADD);

    // Read-first behaviour on a store.
    applyStimulus(1'b1, 4'b1111, 32'h0000_0030, 32'h0000_0001);
    applyStimulus(1'b1, 4'b1111, 32'h0000_0030, 32'h0000_0002);
    checkOutput("read_first_old", data_sram_rdata, 32'h0000_0001);
    applyStimulus(1'b1, 4'b0000, 32'h0000_0030, 32'h0);
    checkOutput("read_first_new", data_sram_rdata, 32'h0000_0002);

    // LED register.
    applyStimulus(1'b1, 4'b1111, A_LED, 32'hFFFF_ABCD);
    checkOutput("led_value", {16'h0, led}, 32'h0000_ABCD);
    applyStimulus(1'b1, 4'b0000, A_LED, 32'h0);
    checkOutput("led_read", data_sram_rdata, 32'h0000_ABCD);
    applyStimulus(1'b1, 4'b1100, A_LED, 32'h1111_1111);
    checkOutput("led_upper_ignored", {16'h0, led}, 32'h0000_ABCD);

    // NUM register.
    applyStimulus(1'b1, 4'b1111, A_NUM, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 4'b0000, A_NUM, 32'h0);
    checkOutput("num_read", data_sram_rdata, 32'hDEAD_BEEF);

    // Timer partial write: lane 0 from wdata, others incremented.
    applyStimulus(1'b1, 4'b1111, A_TIMER, 32'h0000_0100);
    applyStimulus(1'b1, 4'b0001, A_TIMER, 32'h0000_00FF);
    checkOutput("timer_pre_write", data_sram_rdata, 32'h0000_0100);
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("timer_partial", data_sram_rdata, 32'h0000_01FF);

    // Timer wrap.
    applyStimulus(1'b1, 4'b1111, A_TIMER, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("timer_max", data_sram_rdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("timer_wrap", data_sram_rdata, 32'h0);

    // Unmapped MMIO offset.
    applyStimulus(1'b1, 4'b0000, A_NUM, 32'h0);
    checkOutput("err_before", {31'h0, mmio_err}, 32'h0);
    applyStimulus(1'b1, 4'b0000, A_BAD, 32'h0);
    checkOutput("unmapped_rdata", data_sram_rdata, 32'h0);
    checkOutput("err_set", {31'h0, mmio_err}, 32'h1);
    applyStimulus(1'b1, 4'b1111, A_BAD, 32'h7777_7777);
    applyStimulus(1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    checkOutput("err_sticky", {31'h0, mmio_err}, 32'h1);
    checkOutput("ram_after_bad", data_sram_rdata, 32'h1122_3344);

    // Reset mid-stream with a live store: nothing must be written.
    resetn = 1'b0;
    applyStimulus(1'b1, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D);
    checkOutput("midrst_rdata", data_sram_rdata, 32'h0);
    checkOutput("midrst_err", {31'h0, mmio_err}, 32'h0);
    checkOutput("midrst_led", {16'h0, led}, 32'h0);
    resetn = 1'b1;
    applyStimulus(1'b1, 4'b0000, 32'h0000_0010, 32'h0);
    checkOutput("midrst_no_write", data_sram_rdata, 32'h1122_3344);
    applyStimulus(1'b1, 4'b0000, A_NUM, 32'h0);
    checkOutput("midrst_num", data_sram_rdata, 32'h0);
    applyStimulus(1'b1, 4'b0000, A_TIMER, 32'h0);
    checkOutput("midrst_timer", data_sram_rdata, 32'h2);

    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the EX-stage data SRAM request interface (en / byte-we / word addr / wdata).
- Single-port synchronous data memory with fixed 1-cycle read latency; MEM stage samples data_sram_rdata the cycle after EX issues.
- A small MMIO window (LED, NUM, TIMER registers) is decoded in front of the RAM so directed tests and board bring-up can observe stores.

Parameters:
- RAM_AW, 16, word-address bits of the RAM array (2^RAM_AW 32-bit words).
- MMIO_HI, 16'hBFAF, addr[31:16] value selecting the MMIO window.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- data_sram_en  in  1  access request, loads and stores
- data_sram_we  in  4  byte write enables; 0000 = read
- data_sram_addr  in  32  word-aligned byte address; addr[1:0] ignored
- data_sram_wdata  in  32  store data, already lane-replicated by the requester
- data_sram_rdata  out  32  read data, valid the cycle after en
- led  out  16  LED register contents
- mmio_err  out  1  sticky flag: access to an unmapped MMIO offset

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk.
  - On reset: data_sram_rdata=0, led=0, NUM=0, TIMER=0, mmio_err=0.
  - RAM contents are not reset.
  - Requests presented while resetn=0 are ignored: no write, no rdata update.
- Decode (when en=1):
  - mmio_sel = (addr[31:16]==MMIO_HI).
  - Else RAM, indexed by addr[RAM_AW+1:2]. Upper bits are ignored, so addresses alias.
- MMIO offsets addr[15:0]:
  - 0x0000 LED: 16 bits; read zero-extended.
  - 0x0004 NUM: 32 bits.
  - 0x0008 TIMER: 32 bits.
  - Any other offset: unmapped; read returns 0, write ignored, mmio_err set to 1. mmio_err clears only on reset.
- Writes:
  - Each byte lane i is written only when en & we[i].
  - LED uses lanes 0-1 only; we[3:2] are ignored for LED.
  - RAM write takes effect at the clock edge.
- Reads: data_sram_rdata is registered.
  - At each edge with en=1 it loads the pre-edge contents of the selected location.
  - Read-first: a store cycle returns the old word.
  - With en=0, rdata holds its previous value.
- Latency: request in cycle N produces rdata in cycle N+1.
  - Back-to-back requests every cycle are supported; no stall or ready signal.
- TIMER:
  - Increments by 1 every cycle out of reset; wraps 0xFFFFFFFF -> 0.
  - A write to TIMER in the same cycle takes priority: written lanes take wdata, unwritten lanes take the incremented value.
  - A read returns the pre-edge value.
- Simultaneous events: only one access per cycle by construction. A store with we=0000 and en=1 is a plain read.
- The requester already gates en/we on exceptions and flushes; this block performs no address-error checks on RAM.
- Sizing target: roughly 150-250 lines RTL. RAM is an inferred reg array with per-byte write.

Test Plan:
- Reset, then write RAM 0x0000_0010 we=1111 wdata=0x11223344; read the same address next cycle -> rdata=0x11223344 one cycle after the read request.
- Byte stores to 0x0000_0020: first write 0xAABBCCDD with we=1111. Then we=0010 wdata=0x5A5A5A5A, then we=1100 wdata=0x12341234. Read back -> 0x1234 5ADD.
- Read-first: word holds 0x0000_0001; store 0x0000_0002 to it. rdata in the following cycle = 0x0000_0001; a subsequent read returns 0x0000_0002.
- MMIO: write LED at 0xBFAF_0000 with wdata 0xFFFF_ABCD we=1111 -> led=0xABCD, and a read returns 0x0000_ABCD. Write NUM 0xDEADBEEF -> reads 0xDEADBEEF.
- TIMER: after reset, read TIMER at cycle k -> value k-1 relative to reset release, consistently increasing. Write we=0001 wdata=0x000000FF when TIMER=0x00000100 -> next value 0x000001FF. Also check wrap from 0xFFFFFFFF to 0.
- Unmapped 0xBFAF_0040 read -> rdata=0, mmio_err=1 and stays set. Assert resetn mid-stream with en=1 we=1111 -> no write occurs, rdata=0, mmio_err=0.
